// File: rtl/conv1d_obi_pkg.sv
// OBI request/response bundles shared by the
// conv1d accelerator and its bus wrapper.
package conv1d_obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/conv1d_accel.sv
// Memory-mapped 1D valid-mode correlation engine:
// x/h/y buffers on an OBI slave, one MAC per cycle.
module conv1d_accel
  import conv1d_obi_pkg::*;
#(
  parameter int N_MAX  = 64,
  parameter int K_MAX  = 8,
  parameter int DATA_W = 16
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  obi_req_t  mem_req_i,
  output obi_resp_t mem_rsp_o,
  input  logic      rst_n,
  input  logic      start,
  output logic      done,
  output logic      done_e,
  output logic      running,
  output logic      running_e
);

  localparam int XAW = $clog2(N_MAX);
  localparam int HAW = $clog2(K_MAX);
  localparam logic [6:0] NMAX7 = 7'(N_MAX);
  localparam logic [3:0] KMAX4 = 4'(K_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_STORE,
    S_FINISH
  } state_t;

  state_t r_state;

  logic [DATA_W-1:0] r_x [N_MAX];
  logic [DATA_W-1:0] r_h [K_MAX];
  logic [31:0]       r_y [N_MAX];

  logic [6:0]     r_cfg_n;
  logic [3:0]     r_cfg_k;
  logic [6:0]     r_n;
  logic [3:0]     r_k;
  logic           r_bad;
  logic [XAW-1:0] r_i;
  logic [HAW-1:0] r_j;
  logic [31:0]    r_acc;
  logic           r_rvalid;
  logic [31:0]    r_rdata;
  logic           r_done;
  logic           r_done_e;
  logic           r_running;
  logic           r_running_e;

  logic [9:0]      w_word;
  logic            w_is_cfg;
  logic            w_is_x;
  logic            w_is_h;
  logic            w_is_y;
  logic            w_rd;
  logic            w_wr;
  logic [31:0]     w_rdata;
  logic [XAW-1:0]  w_xidx;
  logic [HAW-1:0]  w_hidx;
  logic [XAW-1:0]  w_widx;
  logic signed [31:0] w_prod;
  logic            w_j_last;
  logic            w_i_last;
  logic            w_cfg_bad;
  logic            w_unused;

  assign w_word   = mem_req_i.addr[11:2];
  assign w_is_cfg = (w_word == 10'h000);
  assign w_is_x   = (w_word[9:6] == 4'h1);
  assign w_is_h   = (w_word[9:3] == 7'h10);
  assign w_is_y   = (w_word[9:6] == 4'h3);
  assign w_widx   = w_word[XAW-1:0];
  assign w_hidx   = w_word[HAW-1:0];

  assign w_rd = mem_req_i.req & ~mem_req_i.we;
  // Host writes are only taken while idle
  assign w_wr = mem_req_i.req & mem_req_i.we
              & (r_state == S_IDLE);

  assign w_unused = ^{mem_req_i.addr[31:12],
                      mem_req_i.addr[1:0],
                      mem_req_i.be[3:2],
                      mem_req_i.wdata[31:16]};

  always_comb begin
    w_rdata = '0;
    unique case (1'b1)
      w_is_cfg: w_rdata = {20'b0, r_cfg_k,
                           1'b0, r_cfg_n};
      w_is_x:   w_rdata = {{(32-DATA_W){1'b0}},
                           r_x[w_widx]};
      w_is_h:   w_rdata = {{(32-DATA_W){1'b0}},
                           r_h[w_hidx]};
      w_is_y:   w_rdata = r_y[w_widx];
      default:  w_rdata = '0;
    endcase
  end

  assign mem_rsp_o.gnt    = mem_req_i.req;
  assign mem_rsp_o.rvalid = r_rvalid;
  assign mem_rsp_o.rdata  = r_rdata;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_cfg_n  <= '0;
      r_cfg_k  <= '0;
    end else begin
      r_rvalid <= mem_req_i.req;
      r_rdata  <= w_rd ? w_rdata : '0;
      if (w_wr && w_is_cfg) begin
        if (mem_req_i.be[0])
          r_cfg_n <= mem_req_i.wdata[6:0];
        if (mem_req_i.be[1])
          r_cfg_k <= mem_req_i.wdata[11:8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr && w_is_x) begin
      if (mem_req_i.be[0])
        r_x[w_widx][7:0] <= mem_req_i.wdata[7:0];
      if (mem_req_i.be[1])
        r_x[w_widx][15:8] <= mem_req_i.wdata[15:8];
    end
    if (w_wr && w_is_h) begin
      if (mem_req_i.be[0])
        r_h[w_hidx][7:0] <= mem_req_i.wdata[7:0];
      if (mem_req_i.be[1])
        r_h[w_hidx][15:8] <= mem_req_i.wdata[15:8];
    end
    if (rst_n && r_state == S_STORE)
      r_y[r_i] <= r_acc;
  end

  assign w_xidx = r_i + XAW'(r_j);
  assign w_prod = $signed(r_x[w_xidx])
                * $signed(r_h[r_j]);

  assign w_j_last = ((4'(r_j) + 4'd1) == r_k);
  assign w_i_last = ((7'(r_i) + 7'(r_k)) == r_n);

  assign w_cfg_bad = (r_cfg_k == 4'd0)
                   | (r_cfg_k > KMAX4)
                   | (r_cfg_n < 7'(r_cfg_k))
                   | (r_cfg_n > NMAX7);

  // Config validity is latched at start and acted on
  // in the first MAC cycle, so a bad run still takes
  // one setup cycle before FINISH.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_n         <= '0;
      r_k         <= '0;
      r_bad       <= 1'b0;
      r_i         <= '0;
      r_j         <= '0;
      r_acc       <= '0;
      r_done      <= 1'b0;
      r_done_e    <= 1'b0;
      r_running   <= 1'b0;
      r_running_e <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_done_e    <= 1'b0;
      r_running   <= 1'b0;
      r_running_e <= 1'b0;
      if (!rst_n) begin
        if (r_state != S_IDLE)
          r_running_e <= 1'b1;
        r_state <= S_IDLE;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (start) begin
              r_n         <= r_cfg_n;
              r_k         <= r_cfg_k;
              r_bad       <= w_cfg_bad;
              r_acc       <= '0;
              r_i         <= '0;
              r_j         <= '0;
              r_running   <= 1'b1;
              r_running_e <= 1'b1;
              r_state     <= S_MAC;
            end
          end
          S_MAC: begin
            if (r_bad) begin
              r_done      <= 1'b1;
              r_done_e    <= 1'b1;
              r_running_e <= 1'b1;
              r_state     <= S_FINISH;
            end else begin
              r_acc <= r_acc + w_prod;
              if (w_j_last)
                r_state <= S_STORE;
              else
                r_j <= r_j + 1'b1;
            end
          end
          S_STORE: begin
            if (w_i_last) begin
              r_done      <= 1'b1;
              r_done_e    <= 1'b1;
              r_running_e <= 1'b1;
              r_state     <= S_FINISH;
            end else begin
              r_i     <= r_i + 1'b1;
              r_j     <= '0;
              r_acc   <= '0;
              r_state <= S_MAC;
            end
          end
          S_FINISH: r_state <= S_IDLE;
          default:  r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign done      = r_done;
  assign done_e    = r_done_e;
  assign running   = r_running;
  assign running_e = r_running_e;

endmodule

// File: tb/tb_conv1d_accel.sv
// Directed bench for conv1d_accel: bus table,
// convolution runs, soft/async reset sequences.
module tb_conv1d_accel;
  import conv1d_obi_pkg::*;

  logic      clk = 1'b0;
  logic      rst_ni;
  logic      rst_n;
  logic      start;
  obi_req_t  mreq;
  obi_resp_t mrsp;
  logic      done;
  logic      done_e;
  logic      running;
  logic      running_e;

  int checks   = 0;
  int failures = 0;

  conv1d_accel dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .mem_req_i (mreq),
    .mem_rsp_o (mrsp),
    .rst_n     (rst_n),
    .start     (start),
    .done      (done),
    .done_e    (done_e),
    .running   (running),
    .running_e (running_e)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic we,
                     input logic [31:0] a,
                     input logic [31:0] d,
                     input logic [3:0] be,
                     input logic [31:0] e,
                     input string nm);
    vec_t v;
    v.we = we; v.addr = a; v.wdata = d;
    v.be = be; v.exp = e; v.nm = nm;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [31:0] a,
                        input logic [31:0] d,
                        input logic [3:0] be);
    @(negedge clk);
    mreq.req = 1'b1; mreq.we = 1'b1;
    mreq.addr = a; mreq.wdata = d; mreq.be = be;
    @(negedge clk);
    mreq.req = 1'b0; mreq.we = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a,
                        output logic [31:0] d);
    @(negedge clk);
    mreq.req = 1'b1; mreq.we = 1'b0;
    mreq.addr = a; mreq.be = 4'hF;
    @(negedge clk);
    mreq.req = 1'b0;
    d = mrsp.rdata;
  endtask

  task automatic rd_chk(input logic [31:0] a,
                        input logic [31:0] e,
                        input string nm);
    logic [31:0] d;
    bus_rd(a, d);
    chk(nm, d, e);
  endtask

  // Pulse start, then count cycles to done_e.
  task automatic run_conv(input int lat,
                          input string nm);
    int first = -1;
    int nd = 0;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= lat + 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        chk({nm, "_run_on"},
            {30'b0, running_e, running}, 32'h3);
      end
      if (done_e) begin
        nd++;
        if (first < 0) first = k;
        chk({nm, "_fin"},
            {29'b0, done, running_e, running},
            32'h6);
      end
    end
    chk({nm, "_lat"}, first, lat);
    chk({nm, "_ndone"}, nd, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    int nd;
    int nre;
    bit found;

    rst_ni = 1'b0;
    rst_n  = 1'b1;
    start  = 1'b0;
    mreq   = '0;
    repeat (3) @(negedge clk);
    chk("rst_out",
        {27'b0, done, done_e, running,
         running_e, mrsp.rvalid}, 32'h0);
    chk("rst_rdata", mrsp.rdata, 32'h0);
    rst_ni = 1'b1;
    rd_chk(32'h000, 32'h0, "rst_cfg");

    add(1, 32'h000, 32'hFFFF_F305, 4'hF, 0, "cfg_w");
    add(0, 32'h000, 0, 0, 32'h305, "cfg_r");
    add(1, 32'h000, 32'hFFFF_FFFF, 4'h1, 0, "cfg_b0");
    add(0, 32'h000, 0, 0, 32'h37F, "cfg_b0_r");
    add(1, 32'h000, 32'h0000_0A00, 4'h2, 0, "cfg_b1");
    add(0, 32'h000, 0, 0, 32'hA7F, "cfg_b1_r");
    add(1, 32'h000, 32'h0000_0305, 4'hF, 0, "cfg_w2");
    add(1, 32'h004, 32'h0000_FFFF, 4'hF, 0, "unm_w");
    add(0, 32'h000, 0, 0, 32'h305, "cfg_keep");
    add(0, 32'h004, 0, 0, 32'h0, "unm_r4");
    add(1, 32'h100, 32'h1, 4'hF, 0, "x0");
    add(1, 32'h104, 32'h2, 4'hF, 0, "x1");
    add(1, 32'h108, 32'h3, 4'hF, 0, "x2");
    add(1, 32'h10C, 32'h4, 4'hF, 0, "x3");
    add(1, 32'h110, 32'h5, 4'hF, 0, "x4");
    add(1, 32'h114, 32'h1111_5678, 4'hF, 0, "x5");
    add(1, 32'h114, 32'hFFFF_AB00, 4'h2, 0, "x5b");
    add(0, 32'h114, 0, 0, 32'hAB78, "x5_be_r");
    add(0, 32'h108, 0, 0, 32'h3, "x2_r");
    add(1, 32'h200, 32'h1, 4'hF, 0, "h0");
    add(1, 32'h204, 32'h0, 4'hF, 0, "h1");
    add(1, 32'h208, 32'hFFFF, 4'hF, 0, "h2");
    add(0, 32'h200, 0, 0, 32'h1, "h0_r");
    add(0, 32'h220, 0, 0, 32'h0, "unm_r220");
    add(0, 32'h400, 0, 0, 32'h0, "unm_r400");

    foreach (tbl[n]) begin
      if (tbl[n].we)
        bus_wr(tbl[n].addr, tbl[n].wdata, tbl[n].be);
      else
        rd_chk(tbl[n].addr, tbl[n].exp, tbl[n].nm);
    end

    run_conv(13, "basic");
    rd_chk(32'h300, 32'hFFFF_FFFE, "basic_y0");
    rd_chk(32'h304, 32'hFFFF_FFFE, "basic_y1");
    rd_chk(32'h308, 32'hFFFF_FFFE, "basic_y2");
    bus_wr(32'h300, 32'h1234, 4'hF);
    rd_chk(32'h300, 32'hFFFF_FFFE, "y_ro");

    bus_wr(32'h000, 32'h808, 4'hF);
    for (int k = 0; k < 8; k++) begin
      bus_wr(32'h100 + 4 * k, 32'h8000, 4'hF);
      bus_wr(32'h200 + 4 * k, 32'h8000, 4'hF);
    end
    run_conv(10, "ovf");
    rd_chk(32'h300, 32'h0, "ovf_y0");
    rd_chk(32'h304, 32'hFFFF_FFFE, "ovf_y1_kept");

    bus_wr(32'h000, 32'h302, 4'hF);
    run_conv(2, "inval");
    rd_chk(32'h300, 32'h0, "inval_y0");
    rd_chk(32'h304, 32'hFFFF_FFFE, "inval_y1");

    // back-to-back read then write
    @(negedge clk);
    mreq.req = 1'b1; mreq.we = 1'b0;
    mreq.addr = 32'h000; mreq.be = 4'hF;
    #1 chk("b2b_gnt_r", mrsp.gnt, 1);
    @(negedge clk);
    chk("b2b_rv_r", mrsp.rvalid, 1);
    chk("b2b_rd_r", mrsp.rdata, 32'h302);
    mreq.we = 1'b1; mreq.addr = 32'h100;
    mreq.wdata = 32'h55;
    #1 chk("b2b_gnt_w", mrsp.gnt, 1);
    @(negedge clk);
    chk("b2b_rv_w", mrsp.rvalid, 1);
    chk("b2b_rd_w", mrsp.rdata, 32'h0);
    mreq.req = 1'b0; mreq.we = 1'b0;
    @(negedge clk);
    chk("b2b_rv_idle", mrsp.rvalid, 0);
    rd_chk(32'h100, 32'h55, "b2b_x0");

    // write during MAC must be dropped
    bus_wr(32'h000, 32'h305, 4'hF);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mreq.req = 1'b1; mreq.we = 1'b1;
    mreq.addr = 32'h100; mreq.wdata = 32'h7;
    mreq.be = 4'hF;
    @(negedge clk);
    mreq.req = 1'b0; mreq.we = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      if (done_e) found = 1'b1;
    end
    chk("macwr_done", found, 1);
    rd_chk(32'h100, 32'h55, "macwr_x0");
    rd_chk(32'h300, 32'h7FD5_8000, "macwr_y0");
    rd_chk(32'h304, 32'hC000_0000, "macwr_y1");

    // soft reset wins over start while idle
    @(negedge clk);
    rst_n = 1'b0; start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0;
    chk("srst_prio",
        {30'b0, running_e, running}, 32'h0);
    @(negedge clk);
    chk("srst_prio_idle",
        {30'b0, running_e, done_e}, 32'h0);

    // soft reset mid-run
    bus_wr(32'h000, 32'h840, 4'hF);
    for (int k = 0; k < 64; k++)
      bus_wr(32'h100 + 4 * k, k, 4'hF);
    for (int k = 0; k < 8; k++)
      bus_wr(32'h200 + 4 * k, 32'h1, 4'hF);
    nd = 0;
    nre = 0;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (done_e) nd++;
      if (running_e) nre++;
      if (k == 20) rst_n = 1'b0;
      if (k == 21) begin
        rst_n = 1'b1;
        chk("srst_pulse",
            {30'b0, running_e, running}, 32'h2);
      end
    end
    chk("srst_nodone", nd, 0);
    chk("srst_nre", nre, 2);
    bus_wr(32'h21C, 32'h2, 4'hF);
    run_conv(514, "rerun");
    rd_chk(32'h300, 32'd35, "rerun_y0");
    rd_chk(32'h3E0, 32'd539, "rerun_y56");

    // async reset mid-run
    bus_wr(32'h000, 32'h305, 4'hF);
    @(negedge clk);
    start = 1'b1;
    mreq.req = 1'b1; mreq.we = 1'b0;
    mreq.addr = 32'h000;
    @(negedge clk);
    start = 1'b0;
    mreq.req = 1'b0;
    chk("ar_pre",
        {29'b0, running_e, running, mrsp.rvalid},
        32'h7);
    #1 rst_ni = 1'b0;
    #1;
    chk("ar_out",
        {27'b0, done, done_e, running,
         running_e, mrsp.rvalid}, 32'h0);
    chk("ar_rdata", mrsp.rdata, 32'h0);
    @(negedge clk);
    rst_ni = 1'b1;
    rd_chk(32'h000, 32'h0, "ar_cfg");
    nd = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done_e || running_e) nd++;
    end
    chk("ar_quiet", nd, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
